sub_serial: RTL

- Bit-serial subtractor; the inverse-operation companion to the team's bit-serial adder. Uses the same en/IDLE→compute→DONE handshake.
- Loads two WIDTH-bit unsigned operands, computes a − b LSB-first over WIDTH cycles with a borrow flop, then holds the result until re-armed.
- Sits beside the adder in the datapath for a serial add/subtract pair, for area-constrained arithmetic.

---
 rtl/sub_serial_if.sv | 22 ++
 rtl/sub_serial.sv | 101 ++++++++++
 2 files changed

// File: rtl/sub_serial_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface sub_serial_if #(
   parameter int unsigned WIDTH = 8
);
   logic             en;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] out;
   logic             borrow_out;
   logic             busy;
   logic             done;

   modport master (
      output en, a, b,
      input  out, borrow_out, busy, done
   );

   modport slave (
      input  en, a, b,
      output out, borrow_out, busy, done
   );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial subtractor: out = a - b, LSB-first over WIDTH cycles, IDLE/SUB/DONE handshake.
// Define SUB_SERIAL_SAT_EN to clamp an underflowing result to zero.
module sub_serial #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = $clog2(WIDTH)
) (
   input logic        clk,
   input logic        rst,
   sub_serial_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SUB    = 2'd1,
      DONE   = 2'd2,
      UNUSED = 2'd3
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] out_q;
   logic [CW-1:0]    count;
   logic             borrow;
   logic             borrow_out_q;
   logic             busy_q;
   logic             done_q;

   logic             diff;
   logic             next_borrow;
   logic             last_bit;

   always_comb begin
      diff        = a_reg[0] ^ b_reg[0] ^ borrow;
      next_borrow = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & borrow) | (b_reg[0] & borrow);
      last_bit    = (count == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         a_reg        <= '0;
         b_reg        <= '0;
         out_q        <= '0;
         count        <= '0;
         borrow       <= 1'b0;
         borrow_out_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.en) begin
                  a_reg  <= bus.a;
                  b_reg  <= bus.b;
                  out_q  <= '0;
                  borrow <= 1'b0;
                  count  <= '0;
                  state  <= SUB;
                  busy_q <= 1'b1;
               end
            end
            SUB: begin
               out_q  <= {diff, out_q[WIDTH-1:1]};
               a_reg  <= a_reg >> 1;
               b_reg  <= b_reg >> 1;
               borrow <= next_borrow;
               count  <= count + CW'(1);
               if (last_bit) begin
                  state        <= DONE;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
                  borrow_out_q <= next_borrow;
`ifdef SUB_SERIAL_SAT_EN
                  // Later assignment overrides the shift on the final cycle.
                  if (next_borrow)
                     out_q <= '0;
`endif
               end
            end
            DONE: begin
               if (bus.en) begin
                  state  <= IDLE;
                  done_q <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out        = out_q;
   assign bus.borrow_out = borrow_out_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule
